// File: rtl/bsr_tap_pkg.sv
// rtl/bsr_tap_pkg.sv - shared TAP state encoding, opcodes and IR constants
//
// Purpose: types and constants used by the TAP FSM and the TAP controller top.
//   tap_state_t    : 16 TAP controller states, 4-bit encoding
//   OP_*           : instruction opcodes decoded from ir_q
//   CAP_IR_PATTERN : value loaded into the IR shift stage in Capture-IR
//   bypass_code()  : all-ones BYPASS opcode for a given IR width

package bsr_tap_pkg;

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PA_DR  = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PA_IR  = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_t;

  localparam int unsigned OP_EXTEST = 0;
  localparam int unsigned OP_SAMPLE = 1;
  localparam int unsigned OP_INTEST = 2;

  // Low two bits of the captured IR are fixed at 01; upper bits are zero.
  localparam logic [1:0] CAP_IR_PATTERN = 2'b01;

  // Ones in the low 'width' bits; callers cast to their IR width.
  function automatic logic [31:0] bypass_code(input int unsigned width);
    logic [31:0] code;
    code = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width) code[i] = 1'b1;
    end
    return code;
  endfunction

endpackage

// File: rtl/bsr_tap_ctrl_if.sv
// rtl/bsr_tap_ctrl_if.sv - test-port and boundary-scan chain signal bundle
//
// Purpose: groups the TAP test port (tms/tdi/tdo/tdo_en), the BSR serial pair
// (bsr_si/bsr_so), the BSR chain controls and the debug view of the IR.
//   master : the side driving the test port and returning bsr_so
//   slave  : the TAP controller

interface bsr_tap_ctrl_if #(
  parameter int unsigned IR_WIDTH = 4
);

  logic                tms;
  logic                tdi;
  logic                tdo;
  logic                tdo_en;
  logic                bsr_si;
  logic                bsr_so;
  logic                capture_en;
  logic                shift_dr;
  logic                update_en;
  logic                mode;
  logic                intest;
  logic [IR_WIDTH-1:0] ir_q;

  modport master (
    output tms, tdi, bsr_so,
    input  tdo, tdo_en, bsr_si, capture_en, shift_dr, update_en, mode, intest, ir_q
  );

  modport slave (
    input  tms, tdi, bsr_so,
    output tdo, tdo_en, bsr_si, capture_en, shift_dr, update_en, mode, intest, ir_q
  );

endinterface

// File: rtl/bsr_tap_fsm.sv
// rtl/bsr_tap_fsm.sv - 16-state TAP controller state machine
//
// Purpose: state register and tms-driven next-state logic, nothing else.
//   clk        in  : test clock, one TCK edge per rising edge
//   rst        in  : synchronous reset, active high, forces TLR
//   tms        in  : test mode select
//   state      out : current state
//   state_next out : state to be entered on the next edge, ignoring rst

module bsr_tap_fsm
  import bsr_tap_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tms,
  output tap_state_t state,
  output tap_state_t state_next
);

  always_ff @(posedge clk) begin
    if (rst) state <= TLR;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      TLR:     state_next = tms ? TLR    : RTI;
      RTI:     state_next = tms ? SEL_DR : RTI;
      SEL_DR:  state_next = tms ? SEL_IR : CAP_DR;
      CAP_DR:  state_next = tms ? EX1_DR : SH_DR;
      SH_DR:   state_next = tms ? EX1_DR : SH_DR;
      EX1_DR:  state_next = tms ? UPD_DR : PA_DR;
      PA_DR:   state_next = tms ? EX2_DR : PA_DR;
      EX2_DR:  state_next = tms ? UPD_DR : SH_DR;
      UPD_DR:  state_next = tms ? SEL_DR : RTI;
      SEL_IR:  state_next = tms ? TLR    : CAP_IR;
      CAP_IR:  state_next = tms ? EX1_IR : SH_IR;
      SH_IR:   state_next = tms ? EX1_IR : SH_IR;
      EX1_IR:  state_next = tms ? UPD_IR : PA_IR;
      PA_IR:   state_next = tms ? EX2_IR : PA_IR;
      EX2_IR:  state_next = tms ? UPD_IR : SH_IR;
      UPD_IR:  state_next = tms ? SEL_DR : RTI;
      default: state_next = TLR;
    endcase
  end

endmodule

// File: rtl/bsr_tap_ctrl.sv
// rtl/bsr_tap_ctrl.sv - TAP controller driving a DW_bc_5 boundary-scan chain
//
// Purpose: TAP FSM, instruction register, bypass register, instruction decode
// into BSR chain controls, and the TDO mux.
//   clk in           : test clock, one TCK edge per rising edge
//   rst in           : synchronous reset, active high
//   bus (slave)      : tms, tdi, bsr_so in; tdo, tdo_en, bsr_si, capture_en,
//                      shift_dr, update_en, mode, intest, ir_q out

module bsr_tap_ctrl
  import bsr_tap_pkg::*;
#(
  parameter int unsigned IR_WIDTH = 4
) (
  input logic            clk,
  input logic            rst,
  bsr_tap_ctrl_if.slave  bus
);

  localparam logic [IR_WIDTH-1:0] IR_BYPASS = IR_WIDTH'(bypass_code(IR_WIDTH));
  localparam logic [IR_WIDTH-1:0] IR_EXTEST = IR_WIDTH'(OP_EXTEST);
  localparam logic [IR_WIDTH-1:0] IR_SAMPLE = IR_WIDTH'(OP_SAMPLE);
  localparam logic [IR_WIDTH-1:0] IR_INTEST = IR_WIDTH'(OP_INTEST);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(CAP_IR_PATTERN);

  tap_state_t          state;
  tap_state_t          state_next;
  logic [IR_WIDTH-1:0] ir_sh;
  logic [IR_WIDTH-1:0] ir_q;
  logic                bypass_q;

  logic is_extest;
  logic is_sample;
  logic is_intest;
  logic bsr_sel;

  bsr_tap_fsm u_fsm (
    .clk        (clk),
    .rst        (rst),
    .tms        (bus.tms),
    .state      (state),
    .state_next (state_next)
  );

  // IR and bypass register. ir_q is forced to BYPASS on the edge that enters
  // TLR, so a tms-only reset behaves the same as rst for the decoded controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_sh    <= '0;
      ir_q     <= IR_BYPASS;
      bypass_q <= 1'b0;
    end else begin
      if (state == CAP_IR)     ir_sh <= IR_CAPTURE;
      else if (state == SH_IR) ir_sh <= {bus.tdi, ir_sh[IR_WIDTH-1:1]};

      if (state_next == TLR)    ir_q <= IR_BYPASS;
      else if (state == UPD_IR) ir_q <= ir_sh;

      if (state == CAP_DR)                  bypass_q <= 1'b0;
      else if (state == SH_DR && !bsr_sel)  bypass_q <= bus.tdi;
    end
  end

  // Unlisted opcodes fall through to BYPASS simply by not matching here.
  always_comb begin
    is_extest = (ir_q == IR_EXTEST);
    is_sample = (ir_q == IR_SAMPLE);
    is_intest = (ir_q == IR_INTEST);
    bsr_sel   = is_extest | is_sample | is_intest;
  end

  // Moore decodes only: nothing here looks at tms.
  always_comb begin
    bus.capture_en = (state == CAP_DR) && bsr_sel;
    bus.shift_dr   = (state == SH_DR)  && bsr_sel;
    bus.update_en  = (state == UPD_DR) && bsr_sel;
    bus.mode       = is_extest | is_intest;
    bus.intest     = is_intest;
    bus.tdo_en     = (state == SH_IR) || (state == SH_DR);
    bus.tdo        = 1'b0;
    if (state == SH_IR)      bus.tdo = ir_sh[0];
    else if (state == SH_DR) bus.tdo = bsr_sel ? bus.bsr_so : bypass_q;
  end

  assign bus.bsr_si = bus.tdi;
  assign bus.ir_q   = ir_q;

endmodule

// File: tb/tb_bsr_tap_ctrl.sv
// tb/tb_bsr_tap_ctrl.sv - scoreboard testbench for bsr_tap_ctrl

module tb_bsr_tap_ctrl;
  import bsr_tap_pkg::*;

  logic clk;
  logic rst;

  bsr_tap_ctrl_if #(.IR_WIDTH(4)) bus ();

  bsr_tap_ctrl #(.IR_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {tdo_en, capture_en, shift_dr, update_en, mode, intest}
  typedef struct packed {
    tap_state_t  st;
    logic [5:0]  ctl;
    logic        tdo;
    logic [3:0]  irq;
    logic        si;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check({nm, "_state"}, 32'(dut.state), 32'(e.st));
      check({nm, "_ctl"}, 32'({bus.tdo_en, bus.capture_en, bus.shift_dr,
                               bus.update_en, bus.mode, bus.intest}), 32'(e.ctl));
      check({nm, "_tdo"}, 32'(bus.tdo), 32'(e.tdo));
      check({nm, "_irq"}, 32'(bus.ir_q), 32'(e.irq));
      check({nm, "_bsr_si"}, 32'(bus.bsr_si), 32'(e.si));
    end
  end

  // Drive one cycle of inputs and push what the outputs must show during it.
  task automatic cyc(input logic r, input logic t, input logic d, input logic so,
                     input tap_state_t st, input logic [5:0] ctl, input logic tdo_e,
                     input logic [3:0] irq, input string nm);
    exp_t e;
    rst        = r;
    bus.tms    = t;
    bus.tdi    = d;
    bus.bsr_so = so;
    e.st  = st;
    e.ctl = ctl;
    e.tdo = tdo_e;
    e.irq = irq;
    e.si  = d;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // From RTI: full IR scan shifting dseq[0] first; ends in RTI.
  // Captured 0001 always shifts out as 1,0,0,0.
  task automatic load_ir(input logic [3:0] dseq, input logic [3:0] ir_old,
                         input logic [1:0] mi, input string nm);
    cyc(0, 1, 0, 0, RTI,    {4'b0000, mi}, 0, ir_old, nm);
    cyc(0, 1, 0, 0, SEL_DR, {4'b0000, mi}, 0, ir_old, nm);
    cyc(0, 0, 0, 0, SEL_IR, {4'b0000, mi}, 0, ir_old, nm);
    cyc(0, 0, 0, 0, CAP_IR, {4'b0000, mi}, 0, ir_old, nm);
    for (int i = 0; i < 4; i++)
      cyc(0, (i == 3), dseq[i], 0, SH_IR, {4'b1000, mi}, (i == 0), ir_old, nm);
    cyc(0, 1, 0, 0, EX1_IR, {4'b0000, mi}, 0, ir_old, nm);
    cyc(0, 0, 0, 0, UPD_IR, {4'b0000, mi}, 0, ir_old, nm);
  endtask

  logic [7:0] so_pat;
  logic [7:0] di_pat;
  logic [3:0] bp_di;
  logic [3:0] bp_so;
  logic [3:0] bp_tdo;
  int         guard;

  initial begin
    rst        = 1'b1;
    bus.tms    = 1'b1;
    bus.tdi    = 1'b0;
    bus.bsr_so = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // TMS-only reset from RTI: TLR after the 3rd tms=1 edge, held after that
    cyc(0, 0, 0, 0, TLR,    6'b000000, 0, 4'hF, "t2_rst");
    cyc(0, 1, 0, 0, RTI,    6'b000000, 0, 4'hF, "t2_rti");
    cyc(0, 1, 0, 0, SEL_DR, 6'b000000, 0, 4'hF, "t2_e1");
    cyc(0, 1, 0, 0, SEL_IR, 6'b000000, 0, 4'hF, "t2_e2");
    cyc(0, 1, 0, 0, TLR,    6'b000000, 0, 4'hF, "t2_e3");
    cyc(0, 1, 0, 0, TLR,    6'b000000, 0, 4'hF, "t2_e4");
    cyc(0, 0, 0, 0, TLR,    6'b000000, 0, 4'hF, "t2_e5");

    // IR scan loading EXTEST; mode rises only after UPD_IR
    load_ir(4'b0000, 4'hF, 2'b00, "t3_ir");
    cyc(0, 0, 0, 0, RTI, 6'b000010, 0, 4'h0, "t3_mode");

    // SAMPLE then 8-bit BSR scan, tdo mirrors bsr_so
    load_ir(4'b0001, 4'h0, 2'b10, "t4_ir");
    cyc(0, 1, 0, 0, RTI,    6'b000000, 0, 4'h1, "t4_rti");
    cyc(0, 0, 0, 0, SEL_DR, 6'b000000, 0, 4'h1, "t4_sel");
    cyc(0, 0, 0, 0, CAP_DR, 6'b010000, 0, 4'h1, "t4_cap");
    so_pat = 8'b0100_1101;
    di_pat = 8'b1001_0110;
    for (int i = 0; i < 8; i++)
      cyc(0, (i == 7), di_pat[i], so_pat[i], SH_DR, 6'b101000, so_pat[i], 4'h1, "t4_sh");
    cyc(0, 1, 0, 0, EX1_DR, 6'b000000, 0, 4'h1, "t4_ex1");
    cyc(0, 0, 0, 0, UPD_DR, 6'b000100, 0, 4'h1, "t4_upd");

    // rst in SH_DR: next cycle TLR/BYPASS, no update pulse
    cyc(0, 1, 0, 0, RTI,    6'b000000, 0, 4'h1, "t1_rti");
    cyc(0, 0, 0, 0, SEL_DR, 6'b000000, 0, 4'h1, "t1_sel");
    cyc(0, 0, 0, 0, CAP_DR, 6'b010000, 0, 4'h1, "t1_cap");
    cyc(1, 0, 1, 1, SH_DR,  6'b101000, 1, 4'h1, "t1_sh");
    cyc(0, 1, 0, 0, TLR,    6'b000000, 0, 4'hF, "t1_tlr0");
    cyc(0, 1, 0, 0, TLR,    6'b000000, 0, 4'hF, "t1_tlr1");
    cyc(0, 1, 0, 0, TLR,    6'b000000, 0, 4'hF, "t1_tlr2");
    cyc(0, 0, 0, 0, TLR,    6'b000000, 0, 4'hF, "t1_tlr3");

    // BYPASS: tdi 1,0,1,1 comes back as 0,1,0,1; bsr_so set opposite to expected
    load_ir(4'b1111, 4'hF, 2'b00, "t5_ir");
    cyc(0, 1, 0, 0, RTI,    6'b000000, 0, 4'hF, "t5_rti");
    cyc(0, 0, 0, 0, SEL_DR, 6'b000000, 0, 4'hF, "t5_sel");
    cyc(0, 0, 0, 0, CAP_DR, 6'b000000, 0, 4'hF, "t5_cap");
    bp_di  = 4'b1101;
    bp_tdo = 4'b1010;
    bp_so  = 4'b0101;
    for (int i = 0; i < 4; i++)
      cyc(0, (i == 3), bp_di[i], bp_so[i], SH_DR, 6'b100000, bp_tdo[i], 4'hF, "t5_sh");
    cyc(0, 1, 0, 0, EX1_DR, 6'b000000, 0, 4'hF, "t5_ex1");
    cyc(0, 0, 0, 0, UPD_DR, 6'b000000, 0, 4'hF, "t5_upd");

    // INTEST with a 5-cycle PA_DR mid-shift
    load_ir(4'b0010, 4'hF, 2'b00, "t6_ir");
    cyc(0, 1, 0, 0, RTI,    6'b000011, 0, 4'h2, "t6_rti");
    cyc(0, 0, 0, 0, SEL_DR, 6'b000011, 0, 4'h2, "t6_sel");
    cyc(0, 0, 0, 0, CAP_DR, 6'b010011, 0, 4'h2, "t6_cap");
    cyc(0, 0, 1, 1, SH_DR,  6'b101011, 1, 4'h2, "t6_sh0");
    cyc(0, 1, 0, 0, SH_DR,  6'b101011, 0, 4'h2, "t6_sh1");
    cyc(0, 0, 0, 0, EX1_DR, 6'b000011, 0, 4'h2, "t6_ex1");
    for (int i = 0; i < 5; i++)
      cyc(0, (i == 4), 0, 1, PA_DR, 6'b000011, 0, 4'h2, "t6_pause");
    cyc(0, 0, 0, 0, EX2_DR, 6'b000011, 0, 4'h2, "t6_ex2");
    cyc(0, 0, 0, 0, SH_DR,  6'b101011, 0, 4'h2, "t6_sh2");
    cyc(0, 1, 0, 1, SH_DR,  6'b101011, 1, 4'h2, "t6_sh3");
    cyc(0, 1, 0, 0, EX1_DR, 6'b000011, 0, 4'h2, "t6_ex1b");
    cyc(0, 0, 0, 0, UPD_DR, 6'b000111, 0, 4'h2, "t6_upd");

    // Unlisted opcode 5 behaves as BYPASS
    load_ir(4'b0101, 4'h2, 2'b11, "t6_ir5");
    cyc(0, 1, 0, 0, RTI,    6'b000000, 0, 4'h5, "t6b_rti");
    cyc(0, 0, 0, 0, SEL_DR, 6'b000000, 0, 4'h5, "t6b_sel");
    cyc(0, 0, 0, 0, CAP_DR, 6'b000000, 0, 4'h5, "t6b_cap");
    cyc(0, 0, 1, 1, SH_DR,  6'b100000, 0, 4'h5, "t6b_sh0");
    cyc(0, 1, 0, 1, SH_DR,  6'b100000, 1, 4'h5, "t6b_sh1");
    cyc(0, 1, 0, 0, EX1_DR, 6'b000000, 0, 4'h5, "t6b_ex1");
    cyc(0, 0, 0, 0, UPD_DR, 6'b000000, 0, 4'h5, "t6b_upd");
    cyc(0, 0, 0, 0, RTI,    6'b000000, 0, 4'h5, "t6b_end");

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
